// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle for seq_alu.
// master: operand source + result consumer; slave: the ALU.
interface seq_alu_if #(parameter int WIDTH = 16);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     input1;
  logic [WIDTH-1:0]     input2;
  logic [3:0]           op_code;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   output1;
  logic [1:0]           err_code;

  modport master (
    output in_valid, input1, input2, op_code, out_ready,
    input  in_ready, out_valid, output1, err_code
  );

  modport slave (
    input  in_valid, input1, input2, op_code, out_ready,
    output in_ready, out_valid, output1, err_code
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle signed ALU: add/sub finish in one cycle, mul/div/mod iterate
// one bit per cycle on operand magnitudes and fix the sign afterwards.
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic    clk,
  input  logic    rst_n,
  seq_alu_if.slave bus
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [3:0]        op_q;
  logic              sign_a, sign_b;
  logic [WIDTH-1:0]  b_mag;
  logic [WIDTH-1:0]  work;     // multiplier bits (mul) / dividend -> quotient (div)
  logic [WIDTH-1:0]  rem;
  logic [W2-1:0]     mcand;
  logic [W2-1:0]     acc;
  logic [W2-1:0]     res_q;
  logic [1:0]        err_q;

  logic              accept, b_zero, is_iter;
  logic [WIDTH-1:0]  in_a_mag, in_b_mag;
  logic [WIDTH:0]    a_ext, b_ext, as_res;
  logic [W2-1:0]     direct_res;
  logic [1:0]        direct_err;
  logic [WIDTH:0]    div_shift, div_trial;
  logic              q_bit;
  logic [WIDTH-1:0]  rem_nxt;

  assign accept   = bus.in_valid & bus.in_ready;
  assign b_zero   = (bus.input2 == '0);
  assign is_iter  = (bus.op_code == OP_MUL) ||
                    (((bus.op_code == OP_DIV) || (bus.op_code == OP_MOD)) && !b_zero);
  assign in_a_mag = bus.input1[WIDTH-1] ? (WIDTH'(0) - bus.input1) : bus.input1;
  assign in_b_mag = bus.input2[WIDTH-1] ? (WIDTH'(0) - bus.input2) : bus.input2;

  // Single-cycle results: exact (WIDTH+1)-bit add/sub, div-by-zero, illegal op
  always_comb begin
    a_ext      = {bus.input1[WIDTH-1], bus.input1};
    b_ext      = {bus.input2[WIDTH-1], bus.input2};
    as_res     = (bus.op_code == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
    direct_res = '0;
    direct_err = 2'b11;
    case (bus.op_code)
      OP_ADD, OP_SUB: begin
        direct_res = {{(WIDTH-1){as_res[WIDTH]}}, as_res};
        direct_err = (as_res[WIDTH] != as_res[WIDTH-1]) ? 2'b01 : 2'b00;
      end
      OP_DIV, OP_MOD: direct_err = 2'b10;
      default:        direct_err = 2'b11;
    endcase
  end

  // One restoring-division step: shift in next dividend bit, try subtracting divisor
  always_comb begin
    div_shift = {rem, work[WIDTH-1]};
    div_trial = div_shift - {1'b0, b_mag};
    q_bit     = ~div_trial[WIDTH];
    rem_nxt   = q_bit ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = is_iter ? CALC : DONE;
      CALC: if (cnt == CNT_LAST) state_nxt = SIGN;
      SIGN: state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands, iterate, sign-correct, hold result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      res_q <= '0;
      err_q <= 2'b00;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q   <= bus.op_code;
          sign_a <= bus.input1[WIDTH-1];
          sign_b <= bus.input2[WIDTH-1];
          b_mag  <= in_b_mag;
          work   <= (bus.op_code == OP_MUL) ? in_b_mag : in_a_mag;
          mcand  <= {{WIDTH{1'b0}}, in_a_mag};
          acc    <= '0;
          rem    <= '0;
          cnt    <= '0;
          if (!is_iter) begin
            res_q <= direct_res;
            err_q <= direct_err;
          end
        end
        CALC: begin
          cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
          if (op_q == OP_MUL) begin
            if (work[0]) acc <= acc + mcand;
            mcand <= mcand << 1;
            work  <= work >> 1;
          end else begin
            rem  <= rem_nxt;
            work <= {work[WIDTH-2:0], q_bit};
          end
        end
        SIGN: begin
          err_q <= 2'b00;
          case (op_q)
            OP_MUL:  res_q <= (sign_a ^ sign_b) ? (W2'(0) - acc) : acc;
            OP_DIV:  res_q <= (sign_a ^ sign_b) ? (W2'(0) - {{WIDTH{1'b0}}, work})
                                                : {{WIDTH{1'b0}}, work};
            default: res_q <= sign_a ? (W2'(0) - {{WIDTH{1'b0}}, rem})
                                     : {{WIDTH{1'b0}}, rem};
          endcase
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.output1   = res_q;
  assign bus.err_code  = err_q;
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed corner cases plus random ops against a
// plain-arithmetic model of the signed ALU.
module tb_seq_alu;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(W)) bus ();
  seq_alu #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // Reference: exact signed arithmetic, truncating division
  function automatic void model(input logic [3:0] op, input longint a, input longint b,
                                output longint r, output longint e);
    longint mx, mn;
    mx = (longint'(1) <<< (W - 1)) - 1;
    mn = -mx - 1;
    r = 0;
    e = 0;
    case (op)
      4'd0: begin r = a + b; if (r > mx || r < mn) e = 1; end
      4'd1: begin r = a - b; if (r > mx || r < mn) e = 1; end
      4'd2: r = a * b;
      4'd3: if (b == 0) e = 2; else r = a / b;
      4'd4: if (b == 0) e = 2; else r = a % b;
      default: e = 3;
    endcase
  endfunction

  // Issue one op, check latency/result, optionally stall the consumer bp cycles
  task automatic run(input logic [3:0] op, input logic signed [W-1:0] a,
                     input logic signed [W-1:0] b, input int bp);
    longint er, ee, held;
    int n, lat, exp_lat;
    model(op, longint'(a), longint'(b), er, ee);
    exp_lat = (op == 4'd2 || ((op == 4'd3 || op == 4'd4) && b != 0)) ? W + 2 : 1;
    bus.out_ready = (bp == 0);
    bus.in_valid  = 1'b1;
    bus.input1    = a;
    bus.input2    = b;
    bus.op_code   = op;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("in_ready_wait", longint'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.input1   = W'($urandom);
    bus.input2   = W'($urandom);
    bus.op_code  = 4'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    chk($sformatf("lat op%0d", op), lat, exp_lat);
    chk($sformatf("res op%0d %0d,%0d", op, a, b), longint'($signed(bus.output1)), er);
    chk($sformatf("err op%0d %0d,%0d", op, a, b), longint'(bus.err_code), ee);
    held = longint'($signed(bus.output1));
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", longint'(bus.out_valid), 1);
      chk("bp_hold", longint'($signed(bus.output1)), held);
      chk("bp_in_ready", longint'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("valid_drop", longint'(bus.out_valid), 0);
    chk("ready_back", longint'(bus.in_ready), 1);
  endtask

  initial begin
    int seen;
    logic [3:0] op;
    logic signed [W-1:0] a, b;
    bus.in_valid  = 1'b0;
    bus.input1    = '0;
    bus.input2    = '0;
    bus.op_code   = '0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", longint'(bus.in_ready), 1);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_output1", longint'(bus.output1), 0);
    chk("rst_err", longint'(bus.err_code), 0);

    run(4'd0, 16'sd11, 16'sd15, 0);
    run(4'd1, 16'sd32000, -16'sd16000, 0);
    run(4'd0, -16'sd32768, -16'sd1, 0);
    run(4'd2, 16'sd32000, 16'sd16000, 0);
    run(4'd2, -16'sd3, 16'sd5, 0);
    run(4'd3, -16'sd7, 16'sd2, 0);
    run(4'd4, -16'sd7, 16'sd2, 0);
    run(4'd3, -16'sd32768, -16'sd1, 0);
    run(4'd3, 16'sd11, 16'sd0, 0);
    run(4'd4, 16'sd11, 16'sd0, 0);
    run(4'd9, 16'sd5, 16'sd6, 0);
    run(4'd2, -16'sd32768, -16'sd32768, 5);

    // Reset in the middle of a mul aborts it
    bus.in_valid = 1'b1;
    bus.input1   = 16'sd123;
    bus.input2   = -16'sd45;
    bus.op_code  = 4'd2;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_in_ready", longint'(bus.in_ready), 1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("abort_no_valid", seen, 0);
    run(4'd0, 16'sd1, 16'sd2, 0);

    // Random mix, including zero divisors, extremes and illegal codes
    for (int k = 0; k < 200; k++) begin
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
      case ($urandom_range(0, 7))
        0:       a = -16'sd32768;
        1:       a = 16'sd32767;
        default: a = W'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = -16'sd1;
        2:       b = W'($urandom_range(1, 9));
        default: b = W'($urandom);
      endcase
      run(op, a, b, ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
